// File: rtl/xvga_pkg.sv
// XVGA 1024x768 @ 60 Hz raster constants and the sync/blank decode shared by the timing generator.
package xvga_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 1344

    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 806

    localparam logic [10:0] H_BLANK_START = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_LAST        = 11'(H_TOTAL - 1);

    localparam logic [9:0]  V_BLANK_START = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]  V_LAST        = 10'(V_TOTAL - 1);

    // Field order fixes the bit layout carried through the delay line.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

    function automatic sync_t decode(input logic [10:0] h, input logic [9:0] v);
        sync_t s;
        s.hsync = !((h >= H_SYNC_START) && (h <= H_SYNC_END));
        s.vsync = !((v >= V_SYNC_START) && (v <= V_SYNC_END));
        s.blank = (h >= H_BLANK_START) || (v >= V_BLANK_START);
        return s;
    endfunction

endpackage

// File: rtl/xvga_timing_sync_delay.sv
// Fixed-depth shift register for the {hsync, vsync, blank} triple; flushes to idle on reset.
module sync_delay
    import xvga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] din,
    output logic [2:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = &{1'b0, clk, rst, en};
            assign dout = din;
        end else begin : g_shift
            logic [2:0] stages [DEPTH];

            // NOTE: every stage is reset so the monitor sees idle sync levels, not stale raster state.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= SYNC_IDLE;
                end else if (en) begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/xvga_timing.sv
// XVGA raster counter with next-state decoded sync/blank, delayed sync copies and a frame counter.
module xvga_timing
    import xvga_pkg::*;
#(
    parameter int DELAY      = 2,
    parameter int FRAME_BITS = 8
) (
    input  logic                  vclock,
    input  logic                  reset,
    output logic [10:0]           hcount,
    output logic [9:0]            vcount,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  blank,
    output logic                  hsync_d,
    output logic                  vsync_d,
    output logic                  blank_d,
    output logic                  frame_start,
    output logic [FRAME_BITS-1:0] frame_count
);

    logic        running;
    logic [10:0] h_cnt, h_next;
    logic [9:0]  v_cnt, v_next;
    sync_t       sync_q, sync_next, sync_dly;
    logic [2:0]  delayed;

    // The first edge after reset holds (0,0) so frame 0 starts with a visible frame_start.
    // NOTE: every variable gets a default first so no path leaves a latch.
    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (running) begin
            if (h_cnt == H_LAST) begin
                h_next = '0;
                v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_next = h_cnt + 11'd1;
            end
        end
        sync_next = decode(h_next, v_next);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            running     <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            sync_q      <= '{hsync: 1'b1, vsync: 1'b1, blank: 1'b0};
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            running     <= 1'b1;
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            sync_q      <= sync_next;
            frame_start <= (h_next == '0) && (v_next == '0);
            if ((h_next == '0) && (v_next == '0))
                frame_count <= frame_count + FRAME_BITS'(1);
        end
    end

    // Shifting is held off on the hold edge so the first DELAY cycles read idle.
    sync_delay #(.DEPTH(DELAY)) u_sync_delay (
        .clk  (vclock),
        .rst  (reset),
        .en   (running),
        .din  (sync_q),
        .dout (delayed)
    );

    assign sync_dly = sync_t'(delayed);
    assign hcount   = h_cnt;
    assign vcount   = v_cnt;
    assign hsync    = sync_q.hsync;
    assign vsync    = sync_q.vsync;
    assign blank    = sync_q.blank;
    assign hsync_d  = sync_dly.hsync;
    assign vsync_d  = sync_dly.vsync;
    assign blank_d  = sync_dly.blank;

endmodule

// File: tb/tb_xvga_timing.sv
// Directed bench for xvga_timing: a DELAY=2 instance for raster/sync checks, a DELAY=0/FRAME_BITS=2 one for bypass and wrap.
module tb_xvga_timing;

    logic        vclock = 1'b0;
    logic        reset  = 1'b1;

    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync, vsync, blank, hsync_d, vsync_d, blank_d, frame_start;
    logic [7:0]  frame_count;

    logic [10:0] d0_hcount;
    logic [9:0]  d0_vcount;
    logic        d0_hsync, d0_vsync, d0_blank, d0_hsync_d, d0_vsync_d, d0_blank_d, d0_frame_start;
    logic [1:0]  d0_frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int bypass_bad = 0;

    xvga_timing #(.DELAY(2), .FRAME_BITS(8)) dut (
        .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .hsync_d(hsync_d), .vsync_d(vsync_d), .blank_d(blank_d),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    xvga_timing #(.DELAY(0), .FRAME_BITS(2)) dut0 (
        .vclock(vclock), .reset(reset), .hcount(d0_hcount), .vcount(d0_vcount),
        .hsync(d0_hsync), .vsync(d0_vsync), .blank(d0_blank),
        .hsync_d(d0_hsync_d), .vsync_d(d0_vsync_d), .blank_d(d0_blank_d),
        .frame_start(d0_frame_start), .frame_count(d0_frame_count)
    );

    always #5 vclock = ~vclock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge vclock);
        #1;
        if ((d0_hsync_d !== d0_hsync) || (d0_vsync_d !== d0_vsync) || (d0_blank_d !== d0_blank))
            bypass_bad++;
    endtask

    task automatic run_to(input logic [10:0] h, input logic [9:0] v);
        int n = 0;
        while (!(hcount == h && vcount == v) && n < 3000) begin
            tick();
            n++;
        end
        check("reach_pos", {11'd0, vcount, hcount}, {11'd0, v, h});
    endtask

    // Jump the line counter mid-line so frame-level events are reached quickly.
    task automatic skip_v(input bit which, input logic [9:0] v);
        if (which == 1'b0) begin
            force dut.v_cnt = v;
            #1;
            release dut.v_cnt;
        end else begin
            force dut0.v_cnt = v;
            #1;
            release dut0.v_cnt;
        end
    endtask

    initial begin
        int hs_fall, hs_rise, bl_rise, hsd_fall, hs_low;
        int vs_low, vs_first, vs_last, n;
        logic bl_767, bl_768;
        logic [1:0] exp_fc [4];

        // Reset state
        repeat (3) @(posedge vclock);
        #1;
        check("rst_hcount", 32'(hcount), 0);
        check("rst_vcount", 32'(vcount), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_blank", 32'(blank), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_hsync_d", 32'(hsync_d), 1);
        check("rst_blank_d", 32'(blank_d), 1);

        // Release: cycle 0 shows frame 0 start
        @(negedge vclock);
        reset = 1'b0;
        tick();
        check("c0_hcount", 32'(hcount), 0);
        check("c0_vcount", 32'(vcount), 0);
        check("c0_blank", 32'(blank), 0);
        check("c0_hsync", 32'(hsync), 1);
        check("c0_frame_start", 32'(frame_start), 1);
        check("c0_frame_count", 32'(frame_count), 1);
        check("c0_blank_d", 32'(blank_d), 1);
        check("c0_d0_frame_count", 32'(d0_frame_count), 1);
        tick();
        check("c1_hcount", 32'(hcount), 1);
        check("c1_frame_start", 32'(frame_start), 0);
        check("c1_blank_d", 32'(blank_d), 1);
        check("c1_hsync_d", 32'(hsync_d), 1);
        tick();
        check("c2_blank_d", 32'(blank_d), 0);

        // One full line
        hs_fall = -1; hs_rise = -1; bl_rise = -1; hsd_fall = -1; hs_low = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!hsync && hs_fall < 0) hs_fall = int'(hcount);
            if (!hsync) hs_low++;
            if (hs_fall >= 0 && hsync && hs_rise < 0) hs_rise = int'(hcount);
            if (blank && bl_rise < 0) bl_rise = int'(hcount);
            if (!hsync_d && hsd_fall < 0) hsd_fall = int'(hcount);
            if (hcount == 11'd1343) break;
            tick();
        end
        check("line_end_hcount", 32'(hcount), 1343);
        check("hsync_fall", 32'(hs_fall), 1048);
        check("hsync_rise", 32'(hs_rise), 1184);
        check("hsync_low_cycles", 32'(hs_low), 136);
        check("blank_rise", 32'(bl_rise), 1024);
        check("hsync_d_fall", 32'(hsd_fall), 1050);
        tick();
        check("wrap_hcount", 32'(hcount), 0);
        check("wrap_vcount", 32'(vcount), 1);
        check("wrap_frame_start", 32'(frame_start), 0);

        // Vertical sync window and bottom blanking
        run_to(11'd1100, 10'd1);
        skip_v(1'b0, 10'd766);
        vs_low = 0; vs_first = -1; vs_last = -1; bl_767 = 1'bx; bl_768 = 1'bx;
        n = 0;
        while (!(hcount == 11'd0 && vcount == 10'd779) && n < 20000) begin
            tick();
            n++;
            if (hcount == 11'd1023 && vcount == 10'd767) bl_767 = blank;
            if (hcount == 11'd0 && vcount == 10'd768) bl_768 = blank;
            if (!vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'({vcount, hcount});
                vs_last = int'({vcount, hcount});
            end
        end
        check("v_reach_779", 32'(vcount), 779);
        check("vsync_low_cycles", 32'(vs_low), 6 * 1344);
        check("vsync_first", 32'(vs_first), {11'd0, 10'd771, 11'd0});
        check("vsync_last", 32'(vs_last), {11'd0, 10'd776, 11'd1343});
        check("blank_767_1023", 32'(bl_767), 0);
        check("blank_768_0", 32'(bl_768), 1);

        // Frame wrap on the DELAY=2 instance
        run_to(11'd1100, 10'd779);
        skip_v(1'b0, 10'd805);
        run_to(11'd1343, 10'd805);
        check("pre_wrap_frame_start", 32'(frame_start), 0);
        tick();
        check("fwrap_hcount", 32'(hcount), 0);
        check("fwrap_vcount", 32'(vcount), 0);
        check("fwrap_frame_start", 32'(frame_start), 1);
        check("fwrap_frame_count", 32'(frame_count), 2);
        check("fwrap_vsync", 32'(vsync), 1);
        tick();
        check("fwrap_pulse_end", 32'(frame_start), 0);

        // FRAME_BITS=2 wrap sequence 1 (already seen), 2, 3, 0, 1
        exp_fc[0] = 2'd2; exp_fc[1] = 2'd3; exp_fc[2] = 2'd0; exp_fc[3] = 2'd1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (d0_hcount != 11'd1100 && n < 1500) begin tick(); n++; end
            skip_v(1'b1, 10'd805);
            n = 0;
            while (!d0_frame_start && n < 3000) begin tick(); n++; end
            check("d0_frame_start_seen", 32'(d0_frame_start), 1);
            check($sformatf("d0_frame_count_%0d", k), 32'(d0_frame_count), 32'(exp_fc[k]));
        end

        // Asynchronous reset mid-frame
        n = 0;
        while (hcount != 11'd1100 && n < 1500) begin tick(); n++; end
        skip_v(1'b0, 10'd299);
        run_to(11'd500, 10'd300);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_hcount", 32'(hcount), 0);
        check("mid_rst_vcount", 32'(vcount), 0);
        check("mid_rst_hsync_d", 32'(hsync_d), 1);
        check("mid_rst_blank_d", 32'(blank_d), 1);
        check("mid_rst_frame_count", 32'(frame_count), 0);
        repeat (3) @(posedge vclock);
        @(negedge vclock);
        reset = 1'b0;
        tick();
        check("post_rst_hcount", 32'(hcount), 0);
        check("post_rst_vcount", 32'(vcount), 0);
        check("post_rst_frame_start", 32'(frame_start), 1);
        check("post_rst_frame_count", 32'(frame_count), 1);
        check("post_rst_blank_d", 32'(blank_d), 1);
        tick();
        check("post_rst_c1_hcount", 32'(hcount), 1);
        check("post_rst_c1_frame_start", 32'(frame_start), 0);

        check("delay0_bypass_diffs", 32'(bypass_bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
